timer_apb_regs: RTL and testbench
=================================

# timer_apb_regs

APB3 register-file responder for the 8-bit timer. It decodes host APB accesses into the timer's control fields: reload data, load strobe, enable, direction and clock select. It returns the live count, and captures the counter's overflow and underflow indications into software-visible write-1-to-clear status bits with maskable interrupts. It sits between the APB fabric and the up/down counter.

## Interface
- DATA_WIDTH, 8, width of pwdata/prdata, TDR and count.
- ADDR_WIDTH, 8, width of paddr.

- pclk  in  1  APB clock; the only clock.
- presetn  in  1  asynchronous active-low reset.
- psel, penable, pwrite  in  1 each  APB control.
- paddr  in  ADDR_WIDTH  byte address.
- pwdata  in  DATA_WIDTH  write data.
- prdata  out  DATA_WIDTH  read data.
- pready  out  1  transfer complete.
- pslverr  out  1  transfer error.
- tdr_reg  out  DATA_WIDTH  reload value to counter.
- load_tdr  out  1  TCR[7], level.
- up_down  out  1  TCR[5]; 1 counts up, 0 counts down.
- enable  out  1  TCR[4].
- cks  out  2  TCR[1:0], prescaler select.
- cnt  in  DATA_WIDTH  live counter value.
- s_ovf, s_udf  in  1 each  sticky counter flags.
- irq_ovf, irq_udf  out  1 each  interrupt requests.

## Operation
- Register map:
  - 0x00 TDR: RW, reset 0x00.
  - 0x01 TCR: RW, reset 0x00. Implemented bits are [7], [5], [4] and [1:0]. Reserved bits ignore writes and read 0.
  - 0x02 TSR: bit0 OVF, bit1 UDF, reset 0. Writing 1 to a bit clears it; writing 0 has no effect.
  - 0x03 TIER: bit0 OVF_IE, bit1 UDF_IE, reset 0. Other bits read 0.
  - 0x04 TCNT: RO, returns cnt.
- Address-out-of-range behaviour:
  - paddr > 0x04: pslverr=1 and prdata=0. A write has no effect.
  - Write to TCNT: pslverr=1 and no state change.
- Handshake FSM:
  - IDLE: pready=0. If psel&&penable, go to ACK.
  - ACK: pready=1 for exactly one cycle, then return to IDLE.
  - Every transfer therefore sees exactly one wait state.
- Write commit: the register write occurs on the pclk edge that ends ACK, when psel&penable&pwrite are all high.
- prdata and pslverr are valid only in ACK and are 0 otherwise.
- load_tdr is a plain level taken from TCR[7]. The counter edge-detects it. Software writes TCR[7]=1, then clears it, to issue further loads. The block never self-clears it.
- Status capture: TSR.OVF sets on the rising edge of s_ovf, detected with a one-cycle delayed copy. UDF uses s_udf the same way. Because s_ovf/s_udf are sticky, a W1C clear stays cleared until the next rising edge.
- Simultaneous status set and W1C clear of the same bit in the same cycle: set wins, bit = 1.
- Interrupts: irq_ovf = TSR.OVF & TIER.OVF_IE and irq_udf = TSR.UDF & TIER.UDF_IE. Both are combinational from flops and glitch-free.

## Timing
- Reset: every output is 0 (prdata, pready, pslverr, tdr_reg, load_tdr, up_down, enable, cks, irq_*). All registers, the edge-detect flops and the FSM (to IDLE) reset to 0.
- Write-to-output latency: control outputs change on the edge that ends ACK, i.e. 2 cycles after the setup phase.
- TCNT read: samples cnt combinationally during ACK.
- Status set latency: TSR bit and irq are high 1 cycle after the s_ovf/s_udf rise.
- psel or penable dropped while in ACK: the transfer is aborted with no write, and the FSM still returns to IDLE.
- Back-to-back transfers: a new setup phase may start the cycle after ACK.
- Reset asserted mid-transfer: the FSM returns to IDLE immediately, pready drops and registers clear.

## Structure
- Package timer_pkg holds:
  - Address constants: ADDR_TDR, ADDR_TCR, ADDR_TSR, ADDR_TIER, ADDR_TCNT.
  - TCR bit positions: TCR_LOAD=7, TCR_UD=5, TCR_EN=4, TCR_CKS=1:0.
  - TSR/TIER bit positions.
  - FSM enum {IDLE, ACK}.
- Sub-module rise_det (async active-low reset, one flop, pulse = in & ~dly) is instantiated twice, for s_ovf and s_udf.

## Test plan
- Reset, then read all 5 addresses: each returns 0x00, pready pulses once per access, and pslverr=0.
- Write TDR=0xA5 and TCR=0xB2: tdr_reg=0xA5, load_tdr=1, up_down=1, enable=1 and cks=2. Readback TCR=0xB2. Write TCR=0xFF and read back 0xB3.
- Raise s_ovf with TIER=0x01: TSR=0x01 and irq_ovf=1 one cycle later. Write TSR=0x01: TSR=0x00 and irq_ovf=0 with s_ovf still held high. Toggle s_ovf low then high: the bit sets again.
- Rise s_udf on the same cycle as a W1C write of 0x02: TSR.UDF=1.
- Write 0x55 to 0x04 and to 0x07: pslverr=1 both times, with no state change. Read 0x07: prdata=0x00 and pslverr=1.
- Assert presetn low during ACK of a TDR write of 0x3C: tdr_reg=0x00, and pready=0 with no further pulse until a new transfer.

Source files
------------

// File: rtl/timer_apb_regs_pkg.sv
// ============================================================================
// timer_pkg : register map, bit positions and FSM states for timer_apb_regs
// rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package timer_pkg;

  localparam int ADDR_TDR  = 'h00;
  localparam int ADDR_TCR  = 'h01;
  localparam int ADDR_TSR  = 'h02;
  localparam int ADDR_TIER = 'h03;
  localparam int ADDR_TCNT = 'h04;

  localparam int TCR_LOAD   = 7;
  localparam int TCR_UD     = 5;
  localparam int TCR_EN     = 4;
  localparam int TCR_CKS_HI = 1;
  localparam int TCR_CKS_LO = 0;
  localparam logic [7:0] TCR_MASK = 8'hB3;

  localparam int TSR_OVF     = 0;
  localparam int TSR_UDF     = 1;
  localparam int TIER_OVF_IE = 0;
  localparam int TIER_UDF_IE = 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACK  = 1'b1
  } apb_state_t;

endpackage

`default_nettype wire

// File: rtl/timer_apb_regs_if.sv
// ============================================================================
// timer_apb_regs_if : APB3 bus bundle between fabric master and timer regs
// rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface timer_apb_regs_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

`default_nettype wire

// File: rtl/timer_apb_regs_rise_det.sv
// ============================================================================
// rise_det : single-flop rising-edge detector, one-cycle pulse
// rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module rise_det (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic din,
  output logic      pulse
);
  logic dly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dly <= 1'b0;
    else        dly <= din;
  end

  assign pulse = din & ~dly;
endmodule

`default_nettype wire

// File: rtl/timer_apb_regs.sv
// ============================================================================
// timer_apb_regs : APB3 register file driving the 8-bit up/down timer
// rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module timer_apb_regs
  import timer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  wire logic                  pclk,
  input  wire logic                  presetn,
  timer_apb_regs_if.slave            apb,
  output logic [DATA_WIDTH-1:0]      tdr_reg,
  output logic                       load_tdr,
  output logic                       up_down,
  output logic                       enable,
  output logic [1:0]                 cks,
  input  wire logic [DATA_WIDTH-1:0] cnt,
  input  wire logic                  s_ovf,
  input  wire logic                  s_udf,
  output logic                       irq_ovf,
  output logic                       irq_udf
);

  apb_state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] tdr_q;
  logic [7:0]            tcr_q;
  logic [1:0]            tsr_q;
  logic [1:0]            tier_q;
  logic [1:0]            tsr_set;
  logic [1:0]            tsr_clr;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ack, sel_tdr, sel_tcr, sel_tsr, sel_tier, sel_tcnt;
  logic                  addr_bad, err, wr_commit;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (apb.psel && apb.penable) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign ack      = (state == ACK);
  assign sel_tdr  = (apb.paddr == ADDR_WIDTH'(ADDR_TDR));
  assign sel_tcr  = (apb.paddr == ADDR_WIDTH'(ADDR_TCR));
  assign sel_tsr  = (apb.paddr == ADDR_WIDTH'(ADDR_TSR));
  assign sel_tier = (apb.paddr == ADDR_WIDTH'(ADDR_TIER));
  assign sel_tcnt = (apb.paddr == ADDR_WIDTH'(ADDR_TCNT));
  assign addr_bad = (apb.paddr >  ADDR_WIDTH'(ADDR_TCNT));
  assign err      = addr_bad | (apb.pwrite & sel_tcnt);

  // A write only lands if the master still holds the access phase through ACK.
  assign wr_commit = ack & apb.psel & apb.penable & apb.pwrite & ~err;

  assign tsr_clr = (wr_commit && sel_tsr) ? apb.pwdata[TSR_UDF:TSR_OVF] : 2'b00;

  rise_det u_ovf_det (.clk(pclk), .rst_n(presetn), .din(s_ovf), .pulse(tsr_set[TSR_OVF]));
  rise_det u_udf_det (.clk(pclk), .rst_n(presetn), .din(s_udf), .pulse(tsr_set[TSR_UDF]));

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tdr_q  <= '0;
      tcr_q  <= '0;
      tier_q <= '0;
      tsr_q  <= '0;
    end else begin
      if (wr_commit && sel_tdr)  tdr_q  <= apb.pwdata;
      if (wr_commit && sel_tcr)  tcr_q  <= apb.pwdata[7:0] & TCR_MASK;
      if (wr_commit && sel_tier) tier_q <= apb.pwdata[TIER_UDF_IE:TIER_OVF_IE];
      // Set is ORed after the clear so a coincident rise wins.
      tsr_q <= tsr_set | (tsr_q & ~tsr_clr);
    end
  end

  always_comb begin
    rdata = '0;
    if      (sel_tdr)  rdata = tdr_q;
    else if (sel_tcr)  rdata = DATA_WIDTH'(tcr_q);
    else if (sel_tsr)  rdata = DATA_WIDTH'(tsr_q);
    else if (sel_tier) rdata = DATA_WIDTH'(tier_q);
    else if (sel_tcnt) rdata = cnt;
  end

  assign apb.pready  = ack;
  assign apb.pslverr = ack & err;
  assign apb.prdata  = (ack && !apb.pwrite) ? rdata : '0;

  assign tdr_reg  = tdr_q;
  assign load_tdr = tcr_q[TCR_LOAD];
  assign up_down  = tcr_q[TCR_UD];
  assign enable   = tcr_q[TCR_EN];
  assign cks      = tcr_q[TCR_CKS_HI:TCR_CKS_LO];
  assign irq_ovf  = tsr_q[TSR_OVF] & tier_q[TIER_OVF_IE];
  assign irq_udf  = tsr_q[TSR_UDF] & tier_q[TIER_UDF_IE];

endmodule

`default_nettype wire

// File: tb/tb_timer_apb_regs.sv
// ============================================================================
// tb_timer_apb_regs : scoreboard bench with register-map reference model
// rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_timer_apb_regs;

  logic       pclk = 1'b0;
  logic       presetn = 1'b0;
  logic [7:0] tdr_reg, cnt;
  logic       load_tdr, up_down, enable, s_ovf, s_udf, irq_ovf, irq_udf;
  logic [1:0] cks;

  always #5 pclk = ~pclk;

  timer_apb_regs_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bus ();

  timer_apb_regs #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
    .pclk(pclk), .presetn(presetn), .apb(bus),
    .tdr_reg(tdr_reg), .load_tdr(load_tdr), .up_down(up_down), .enable(enable),
    .cks(cks), .cnt(cnt), .s_ovf(s_ovf), .s_udf(s_udf),
    .irq_ovf(irq_ovf), .irq_udf(irq_udf)
  );

  typedef struct {
    bit         is_read;
    logic [7:0] rdata;
    bit         err;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0, miscompares = 0;
  int   pready_seen = 0, pready_expected = 0;

  // Reference model: software-visible register contents
  logic [7:0] m_tdr, m_tcr, m_tsr, m_tier;
  bit         m_ovf_lvl, m_udf_lvl;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_tdr = 0; m_tcr = 0; m_tsr = 0; m_tier = 0;
    m_ovf_lvl = 0; m_udf_lvl = 0;
  endfunction

  function automatic logic [7:0] model_read(logic [7:0] a);
    case (a)
      8'h00:   return m_tdr;
      8'h01:   return m_tcr;
      8'h02:   return m_tsr;
      8'h03:   return m_tier;
      8'h04:   return cnt;
      default: return 8'h00;
    endcase
  endfunction

  function automatic void model_write(logic [7:0] a, logic [7:0] d);
    case (a)
      8'h00: m_tdr = d;
      8'h01: m_tcr = {d[7], 1'b0, d[5], d[4], 2'b00, d[1:0]};
      8'h02: m_tsr = m_tsr & ~{6'b0, d[1:0]};
      8'h03: m_tier = {6'b0, d[1:0]};
      default: ;
    endcase
  endfunction

  // Sticky inputs: a 0->1 change sets the matching status bit.
  function automatic void model_levels(bit o, bit u);
    if (o && !m_ovf_lvl) m_tsr[0] = 1'b1;
    if (u && !m_udf_lvl) m_tsr[1] = 1'b1;
    m_ovf_lvl = o;
    m_udf_lvl = u;
  endfunction

  function automatic void check_outputs();
    check("tdr_reg",  tdr_reg,  m_tdr);
    check("load_tdr", load_tdr, m_tcr[7]);
    check("up_down",  up_down,  m_tcr[5]);
    check("enable",   enable,   m_tcr[4]);
    check("cks",      cks,      m_tcr[1:0]);
    check("irq_ovf",  irq_ovf,  m_tsr[0] & m_tier[0]);
    check("irq_udf",  irq_udf,  m_tsr[1] & m_tier[1]);
    check("pready_count", pready_seen, pready_expected);
  endfunction

  always @(negedge pclk) begin
    if (bus.pready === 1'b1) begin
      pready_seen++;
      if (sb.size() == 0) begin
        check("unexpected_pready", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.is_read) check("prdata", bus.prdata, e.rdata);
        check("pslverr", bus.pslverr, e.err);
      end
    end else begin
      check("idle_prdata",  bus.prdata,  0);
      check("idle_pslverr", bus.pslverr, 0);
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the commit edge.
  task automatic xfer(input bit wr, input logic [7:0] a, input logic [7:0] d,
                      input bit abort = 1'b0, input bit udf_at_ack = 1'b0);
    exp_t e;
    e.is_read = !wr;
    e.rdata   = model_read(a);
    e.err     = (a > 8'h04) || (wr && a == 8'h04);
    sb.push_back(e);
    pready_expected++;
    bus.psel = 1; bus.penable = 0; bus.pwrite = wr; bus.paddr = a; bus.pwdata = d;
    @(posedge pclk); #1;
    bus.penable = 1;
    @(posedge pclk); #1;
    if (abort) begin bus.psel = 0; bus.penable = 0; end
    if (udf_at_ack) s_udf = 1'b1;
    @(posedge pclk); #1;
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0;
    if (wr && !abort && !e.err) model_write(a, d);
    model_levels(s_ovf, s_udf);
    check_outputs();
  endtask

  task automatic set_flags(input bit o, input bit u);
    s_ovf = o; s_udf = u;
    @(posedge pclk); #1;
    model_levels(o, u);
    check_outputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = 0; bus.pwdata = 0;
    cnt = 8'h00; s_ovf = 0; s_udf = 0;
    model_reset();
    #12;
    check_outputs();
    check("reset_pready", bus.pready, 0);
    @(posedge pclk); #1;
    presetn = 1'b1;
    @(posedge pclk); #1;

    for (int a = 0; a < 5; a++) xfer(1'b0, 8'(a), 8'h00);

    xfer(1'b1, 8'h00, 8'hA5);
    xfer(1'b1, 8'h01, 8'hB2);
    check("tcr_b2_cks", cks, 2'd2);
    xfer(1'b0, 8'h01, 8'h00);
    xfer(1'b1, 8'h01, 8'hFF);
    xfer(1'b0, 8'h01, 8'h00);

    xfer(1'b1, 8'h03, 8'h01);
    s_ovf = 1'b1;
    #1 check("irq_ovf_before_edge", irq_ovf, 0);
    @(posedge pclk); #1;
    check("irq_ovf_one_cycle", irq_ovf, 1);
    model_levels(1'b1, 1'b0);
    xfer(1'b0, 8'h02, 8'h00);
    xfer(1'b1, 8'h02, 8'h01);
    xfer(1'b0, 8'h02, 8'h00);
    set_flags(1'b0, 1'b0);
    set_flags(1'b1, 1'b0);
    xfer(1'b0, 8'h02, 8'h00);

    xfer(1'b1, 8'h03, 8'h03);
    xfer(1'b1, 8'h02, 8'h02, 1'b0, 1'b1);
    check("udf_set_wins", irq_udf, 1);
    xfer(1'b0, 8'h02, 8'h00);

    cnt = 8'h5A;
    xfer(1'b0, 8'h04, 8'h00);
    xfer(1'b1, 8'h04, 8'h55);
    xfer(1'b1, 8'h07, 8'h55);
    xfer(1'b0, 8'h07, 8'h00);
    xfer(1'b1, 8'h00, 8'h77, 1'b1);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) == 0) set_flags(1'($urandom), 1'($urandom));
      cnt = 8'($urandom);
      xfer(1'($urandom), 8'($urandom_range(0, 7)), 8'($urandom));
    end

    set_flags(1'b0, 1'b0);
    xfer(1'b1, 8'h00, 8'h81);
    bus.psel = 1; bus.penable = 0; bus.pwrite = 1; bus.paddr = 8'h00; bus.pwdata = 8'h3C;
    @(posedge pclk); #1;
    bus.penable = 1;
    @(posedge pclk); #1;
    presetn = 1'b0;
    #1;
    model_reset();
    check("rst_mid_pready", bus.pready, 0);
    check_outputs();
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0;
    repeat (2) @(posedge pclk);
    #1 presetn = 1'b1;
    repeat (3) @(posedge pclk);
    #1 check_outputs();
    xfer(1'b0, 8'h00, 8'h00);

    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
